turn_controller: RTL
====================

TURN_CONTROLLER -- requirements
Module: turn_controller

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 50000000, meaning clock cycles per one-second timer tick.
REQ-002 SHALL have parameter TURN_SECONDS, default 10, meaning the turn time limit reload value (1..15).
REQ-003 SHALL have port clock, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, level; begins or restarts a game.
REQ-006 SHALL have port confirm, input, 1, raw button level; rising edge detected internally.
REQ-007 SHALL have ports select_row and select_col, input, 3 each, the cursor cell from the cursor-move block.
REQ-008 SHALL have port cell_free, input, 1, high when the board cell at select_row/select_col is empty.
REQ-009 SHALL have ports win_detect and board_full, input, 1 each, board evaluation valid in CHECK.
REQ-010 SHALL have port state, output, 3, current FSM state; 3'b000 enables cursor movement.
REQ-011 SHALL have ports write_en (1), write_row (3), write_col (3), output, board write strobe and address.
REQ-012 SHALL have ports clear_board (1) and player (1), output; player 0 or 1 is the active player.
REQ-013 SHALL have ports winner (2) and seconds_left (4), output; winner 00 none, 01 P0, 10 P1, 11 draw.

Function
REQ-014 SHALL encode states as SELECT=000, PLACE=001, CHECK=010, SWITCH=011, WIN=100, DRAW=101, IDLE=110.
REQ-015 SHALL, in IDLE, WIN or DRAW with start=1, pulse clear_board for one cycle, set player=0 and winner=00, reload the timer, and enter SELECT next cycle.
REQ-016 SHALL register confirm through two flops; an edge is confirm_q1 & !confirm_q2; edges outside SELECT are discarded.
REQ-017 SHALL, in SELECT on a confirm edge with cell_free=1, select_row<=4 and select_col<=4, latch write_row/write_col from select_row/select_col and enter PLACE.
REQ-018 SHALL ignore a confirm edge in SELECT when cell_free=0 or either coordinate >4; the FSM stays in SELECT with no write.
REQ-019 SHALL assert write_en for exactly the one cycle spent in PLACE, then enter CHECK.
REQ-020 SHALL spend exactly one cycle in CHECK.
REQ-021 SHALL exit CHECK with priority win_detect (to WIN, winner=player+1) over board_full (to DRAW, winner=11) over neither (to SWITCH).
REQ-022 SHALL, in SWITCH, toggle player, reload the timer, and enter SELECT after one cycle.
REQ-023 SHALL hold WIN and DRAW until start=1; confirm and timer are inert there.
REQ-024 SHALL give confirm-edge-to-write_en latency of exactly 1 cycle (SELECT->PLACE) and confirm-edge-to-next-SELECT of 4 cycles.

Reset
REQ-025 SHALL, on reset=1 at a clock edge, force state=IDLE, player=0, winner=00, write_en=0, clear_board=0, write_row=0, write_col=0, confirm flops=0, prescaler=0, seconds_left=TURN_SECONDS.
REQ-026 SHALL give reset priority over start, confirm and timeout in the same cycle, including mid-PLACE (no write_en issued).

Configuration
REQ-027 SHALL, with macro TURN_TIMEOUT_EN defined, run a prescaler counting 0..TICKS_PER_SEC-1 in SELECT only, and decrement seconds_left at each prescaler wrap.
REQ-028 SHALL, with TURN_TIMEOUT_EN defined, enter SWITCH with no write when seconds_left reaches 0 and the prescaler wraps; a same-cycle valid confirm edge wins over timeout.
REQ-029 SHALL, without TURN_TIMEOUT_EN, omit prescaler and countdown logic and hold seconds_left at TURN_SECONDS constantly.

Verification
REQ-030 SHALL cover: reset, then start=1 for 1 cycle -> clear_board pulse 1 cycle, state=000, player=0.
REQ-031 SHALL cover: SELECT, select=(2,3), cell_free=1, confirm edge -> write_en 1 cycle with row 2, col 3, CHECK, SWITCH, player=1, state=000 four cycles after the edge.
REQ-032 SHALL cover: confirm edge with cell_free=0, and with select_col=5 -> no write_en, state stays 000.
REQ-033 SHALL cover: win_detect=1 and board_full=1 in CHECK with player=1 -> state=100, winner=10; confirm ignored until start.
REQ-034 SHALL cover: TURN_TIMEOUT_EN, TICKS_PER_SEC=4, TURN_SECONDS=2, no confirm -> seconds_left 2,1,0 then SWITCH, player toggles, seconds_left=2.
REQ-035 SHALL cover: reset asserted during PLACE -> state=110, write_en=0 next cycle.

Source files
------------

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - turn sequencing FSM for a two-player board game; optional turn timer under TURN_TIMEOUT_EN
module turn_controller #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TURN_SECONDS  = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       confirm,
  input  logic [2:0] select_row,
  input  logic [2:0] select_col,
  input  logic       cell_free,
  input  logic       win_detect,
  input  logic       board_full,
  output logic [2:0] state,
  output logic       write_en,
  output logic [2:0] write_row,
  output logic [2:0] write_col,
  output logic       clear_board,
  output logic       player,
  output logic [1:0] winner,
  output logic [3:0] seconds_left
);

  typedef enum logic [2:0] {
    ST_SELECT = 3'b000,
    ST_PLACE  = 3'b001,
    ST_CHECK  = 3'b010,
    ST_SWITCH = 3'b011,
    ST_WIN    = 3'b100,
    ST_DRAW   = 3'b101,
    ST_IDLE   = 3'b110
  } state_t;

  localparam logic [3:0] SECS_RELOAD = 4'(TURN_SECONDS);

  state_t     state_q, state_d;
  logic       player_q, player_d;
  logic [1:0] winner_q, winner_d;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       clear_q, clear_d;
  logic       confirm_q1, confirm_q2;

  logic       confirm_edge;
  logic       pick_valid;
  logic       timeout;

  // A pick is accepted only for a fresh press on an empty cell inside the 5x5 board.
  assign confirm_edge = confirm_q1 & ~confirm_q2;
  assign pick_valid   = confirm_edge & cell_free &
                        (select_row <= 3'd4) & (select_col <= 3'd4);

`ifdef TURN_TIMEOUT_EN
  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [3:0]         secs_q, secs_d;
  logic               tick_wrap;
  logic               reload;

  assign tick_wrap = (presc_q == PRESC_LAST);
  assign timeout   = (state_q == ST_SELECT) & tick_wrap & (secs_q == 4'd0);
  assign reload    = (state_q == ST_SWITCH) |
                     (start & ((state_q == ST_IDLE) | (state_q == ST_WIN) | (state_q == ST_DRAW)));

  // Prescaler only runs while a player is choosing; the countdown reloads at each new turn or game.
  always_comb begin
    presc_d = '0;
    secs_d  = secs_q;
    if (state_q == ST_SELECT) begin
      if (tick_wrap) begin
        if (secs_q != 4'd0) begin
          secs_d = secs_q - 4'd1;
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
    if (reload) begin
      secs_d = SECS_RELOAD;
    end
  end

  // Timer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      secs_q  <= SECS_RELOAD;
    end else begin
      presc_q <= presc_d;
      secs_q  <= secs_d;
    end
  end

  assign seconds_left = secs_q;
`else
  assign timeout      = 1'b0;
  assign seconds_left = SECS_RELOAD;
`endif

  // Next-state and registered-output logic of the turn FSM.
  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    winner_d = winner_q;
    row_d    = row_q;
    col_d    = col_q;
    clear_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_WIN, ST_DRAW: begin
        if (start) begin
          clear_d  = 1'b1;
          player_d = 1'b0;
          winner_d = 2'b00;
          state_d  = ST_SELECT;
        end
      end
      ST_SELECT: begin
        if (pick_valid) begin
          row_d   = select_row;
          col_d   = select_col;
          state_d = ST_PLACE;
        end else if (timeout) begin
          state_d = ST_SWITCH;
        end
      end
      ST_PLACE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (win_detect) begin
          winner_d = player_q ? 2'b10 : 2'b01;
          state_d  = ST_WIN;
        end else if (board_full) begin
          winner_d = 2'b11;
          state_d  = ST_DRAW;
        end else begin
          state_d  = ST_SWITCH;
        end
      end
      ST_SWITCH: begin
        player_d = ~player_q;
        state_d  = ST_SELECT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register, confirm synchroniser and latched write address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      player_q   <= 1'b0;
      winner_q   <= 2'b00;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      clear_q    <= 1'b0;
      confirm_q1 <= 1'b0;
      confirm_q2 <= 1'b0;
    end else begin
      state_q    <= state_d;
      player_q   <= player_d;
      winner_q   <= winner_d;
      row_q      <= row_d;
      col_q      <= col_d;
      clear_q    <= clear_d;
      confirm_q1 <= confirm;
      confirm_q2 <= confirm_q1;
    end
  end

  assign state       = state_q;
  assign write_en    = (state_q == ST_PLACE);
  assign write_row   = row_q;
  assign write_col   = col_q;
  assign clear_board = clear_q;
  assign player      = player_q;
  assign winner      = winner_q;

endmodule
